spi_receiver: RTL

- Slave-side receiver for the LED-strip SPI link: the receive end of the byte-wide master transmitter.
- Samples `spi_input_data` on rising edges of `spi_input_clock`. Both inputs are asynchronous to `spi_clk`.
- Assembles bytes MSB first and presents each completed byte with a one-cycle valid strobe.
- Used in loopback/self-test builds and in strip-emulation targets, so that transmitted frames can be checked on-chip.

---
 rtl/spi_receiver.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_receiver.sv
// spi_receiver: slave-side SPI byte receiver for the LED-strip link (MSB first, rising-edge sampling).
// Latency: byte_valid in the 4th spi_clk cycle after the 8th input-clock rise is registered (SYNC_STAGES=2).
// Backpressure: none; each completed byte overwrites spi_data_out and must be captured on spi_byte_valid.
// Optional feature macro: SPI_RX_START_FRAME_EN (start-frame detection on 4 consecutive 0x00 bytes).

module spi_receiver #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       spi_clk,
    input  logic       spi_reset_n,
    input  logic       spi_input_clock,
    input  logic       spi_input_data,
    output logic [7:0] spi_data_out,
    output logic       spi_byte_valid,
    output logic       spi_rx_active,
    output logic       spi_frame_error,
    output logic       spi_start_frame
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);

    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_ONE = ARM_W'(1);

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'd0,
        STATE_SHIFT   = 2'd1,
        STATE_DELIVER = 2'd2,
        STATE_ERROR   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and rising-edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdat_sync;
    logic                   r_sclk_prev;
    logic [ARM_W-1:0]       r_arm_cnt;

    logic w_sclk;
    logic w_sdat;
    logic w_armed;
    logic w_edge;

    // Bring serial clock and data into the spi_clk domain through SYNC_STAGES flops each
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            r_sclk_sync <= '0;
            r_sdat_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_input_clock};
            r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], spi_input_data};
            r_sclk_prev <= w_sclk;
        end
    end

    // Hold off edge detection until the synchronizer has flushed its reset value,
    // so an input clock that idles high across reset is not mistaken for a rise
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            r_arm_cnt <= '0;
        end else if (r_arm_cnt != ARM_MAX) begin
            r_arm_cnt <= r_arm_cnt + ARM_ONE;
        end
    end

    assign w_sclk  = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdat  = r_sdat_sync[SYNC_STAGES-1];
    assign w_armed = (r_arm_cnt == ARM_MAX);
    assign w_edge  = w_armed & w_sclk & ~r_sclk_prev;

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [7:0]      r_shift;
    logic [3:0]      r_bit_cnt;
    logic [TO_W-1:0] r_to_cnt;

    state_t          w_state_nxt;
    logic [7:0]      w_shift_nxt;
    logic [3:0]      w_bit_cnt_nxt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic [TO_W-1:0] w_to_inc;
    logic            w_deliver;
    logic            w_error;

    // Saturating increment: the timeout counter must never wrap back to a small value
    assign w_to_inc = (r_to_cnt == TO_MAX) ? TO_MAX : (r_to_cnt + TO_ONE);

    // State register and datapath registers
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            r_state   <= STATE_IDLE;
            r_shift   <= 8'h00;
            r_bit_cnt <= 4'd0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    // Next-state and datapath decisions; an edge always takes priority over the timeout
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_deliver     = 1'b0;
        w_error       = 1'b0;

        case (r_state)
            STATE_IDLE: begin
                w_to_cnt_nxt = '0;
                if (w_edge) begin
                    w_shift_nxt   = {7'b0, w_sdat};
                    w_bit_cnt_nxt = 4'd1;
                    w_state_nxt   = STATE_SHIFT;
                end
            end

            STATE_SHIFT: begin
                if (w_edge) begin
                    w_shift_nxt   = {r_shift[6:0], w_sdat};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_to_cnt_nxt  = '0;
                    if (r_bit_cnt == 4'd7) begin
                        w_state_nxt = STATE_DELIVER;
                    end
                end else begin
                    w_to_cnt_nxt = w_to_inc;
                    if (w_to_inc == TO_MAX) begin
                        w_state_nxt = STATE_ERROR;
                    end
                end
            end

            STATE_DELIVER: begin
                w_deliver     = 1'b1;
                w_bit_cnt_nxt = 4'd0;
                w_to_cnt_nxt  = '0;
                w_state_nxt   = STATE_IDLE;
            end

            STATE_ERROR: begin
                w_error       = 1'b1;
                w_shift_nxt   = 8'h00;
                w_bit_cnt_nxt = 4'd0;
                w_to_cnt_nxt  = '0;
                w_state_nxt   = STATE_IDLE;
            end

            default: begin
                w_shift_nxt   = 8'h00;
                w_bit_cnt_nxt = 4'd0;
                w_to_cnt_nxt  = '0;
                w_state_nxt   = STATE_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [7:0] r_data_out;
    logic       r_byte_valid;
    logic       r_frame_error;

    // Capture the completed byte and raise the one-cycle strobes
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            r_data_out    <= 8'h00;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_byte_valid  <= w_deliver;
            r_frame_error <= w_error;
            if (w_deliver) begin
                r_data_out <= r_shift;
            end
        end
    end

    assign spi_data_out    = r_data_out;
    assign spi_byte_valid  = r_byte_valid;
    assign spi_frame_error = r_frame_error;
    assign spi_rx_active   = (r_state == STATE_SHIFT);

`ifdef SPI_RX_START_FRAME_EN
    // ------------------------------------------------------------------
    // Start-frame detection: 4 consecutive 0x00 bytes (32 zero bits)
    // ------------------------------------------------------------------
    logic [2:0] r_zero_cnt;
    logic       r_start_frame;

    // Count consecutive zero bytes; pulse once when the 4th arrives, alongside its valid strobe
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            r_zero_cnt    <= 3'd0;
            r_start_frame <= 1'b0;
        end else begin
            r_start_frame <= 1'b0;
            if (w_error) begin
                r_zero_cnt <= 3'd0;
            end else if (w_deliver) begin
                if (r_shift == 8'h00) begin
                    if (r_zero_cnt != 3'd7) begin
                        r_zero_cnt <= r_zero_cnt + 3'd1;
                    end
                    r_start_frame <= (r_zero_cnt == 3'd3);
                end else begin
                    r_zero_cnt <= 3'd0;
                end
            end
        end
    end

    assign spi_start_frame = r_start_frame;
`else
    assign spi_start_frame = 1'b0;
`endif

endmodule
